// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI master transmitter.
//   spi_state_e  : frame sequencer states
//   *_PULSES     : sclk pulses per frame (preamble, data, trailer)
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    CLOCK = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  localparam int unsigned PRE_PULSES   = 1;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned TRAIL_PULSES = 1;
  localparam int unsigned TOTAL_PULSES = PRE_PULSES + DATA_BITS + TRAIL_PULSES;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
//   clk, rst_n : system clock, asynchronous active-low reset
//   enable     : count while high; counter is held at zero while low, so it
//                restarts from zero whenever enable rises
//   tick       : one-cycle pulse on every CLK_DIV-th enabled cycle
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// Byte-oriented SPI master transmitter.
// Frame: LEAD (cs low, sclk low, CLK_DIV cycles), 10 sclk pulses (preamble,
// DATA_W data bits MSB first, trailer), TRAIL (CLK_DIV cycles), then a
// one-cycle done with cs high. mosi changes on rising sclk; the slave
// samples on falling sclk.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   start, din : frame request and byte (sampled/latched in IDLE only)
//   sclk, mosi, cs : SPI bus (sclk idles low, cs active low)
//   busy, done : frame in progress, one-cycle end-of-frame pulse
// Optional (macro SPI_MASTER_MISO_EN):
//   miso    : sampled on falling sclk of the data pulses, MSB first
//   rx_data : received byte, updated in the done cycle
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              sclk,
  output logic              mosi,
  output logic              cs,
  output logic              busy,
  output logic              done
`ifdef SPI_MASTER_MISO_EN
  ,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data
`endif
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_master_tx: CLK_DIV must be at least 1");
  end

  localparam int unsigned PULSES =
    (DATA_W == DATA_BITS) ? TOTAL_PULSES : PRE_PULSES + DATA_W + TRAIL_PULSES;
  localparam logic [4:0] LAST_HALF  = 5'(2 * PULSES - 1);
  localparam logic [4:0] FIRST_DATA = 5'(PRE_PULSES);
  localparam logic [4:0] LAST_DATA  = 5'(PRE_PULSES + DATA_W - 1);

  spi_state_e        r_state, w_state_nxt;
  logic [4:0]        r_edge,  w_edge_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_sclk,  w_sclk_nxt;
  logic              r_mosi,  w_mosi_nxt;
  logic              r_cs,    w_cs_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_done,  w_done_nxt;
  logic              w_tick;
  logic [4:0]        w_rise_p;

`ifdef SPI_MASTER_MISO_EN
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [DATA_W-1:0] r_rx_data,  w_rx_data_nxt;
  logic [4:0]        w_fall_p;

  // Pulse whose high phase ends on this tick (even half-period index).
  assign w_fall_p = r_edge >> 1;
`endif

  // Pulse whose high phase starts on this tick (odd half-period index).
  assign w_rise_p = 5'((r_edge + 5'd1) >> 1);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (r_state != IDLE),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_edge  <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_edge  <= w_edge_nxt;
      r_shift <= w_shift_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_cs    <= w_cs_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef SPI_MASTER_MISO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift <= '0;
      r_rx_data  <= '0;
    end else begin
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
    end
  end

  assign rx_data = r_rx_data;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_edge_nxt  = r_edge;
    w_shift_nxt = r_shift;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_cs_nxt    = r_cs;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef SPI_MASTER_MISO_EN
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
`endif

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = LEAD;
          w_shift_nxt = din;
          w_cs_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_sclk_nxt  = 1'b0;
          w_mosi_nxt  = 1'b0;
        end
      end

      LEAD: begin
        if (w_tick) begin
          // Rising edge of the preamble pulse.
          w_state_nxt = CLOCK;
          w_edge_nxt  = '0;
          w_sclk_nxt  = 1'b1;
          w_mosi_nxt  = 1'b0;
        end
      end

      CLOCK: begin
        if (w_tick) begin
          if (r_edge == LAST_HALF) begin
            w_state_nxt = TRAIL;
            w_edge_nxt  = '0;
            w_sclk_nxt  = 1'b0;
          end else begin
            w_edge_nxt = r_edge + 5'd1;
            if (!r_edge[0]) begin
              w_sclk_nxt = 1'b0;
`ifdef SPI_MASTER_MISO_EN
              if ((w_fall_p >= FIRST_DATA) && (w_fall_p <= LAST_DATA)) begin
                w_rx_shift_nxt = {r_rx_shift[DATA_W-2:0], miso};
              end
`endif
            end else begin
              w_sclk_nxt = 1'b1;
              if ((w_rise_p >= FIRST_DATA) && (w_rise_p <= LAST_DATA)) begin
                w_mosi_nxt  = r_shift[DATA_W-1];
                w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
              end else begin
                w_mosi_nxt = 1'b0;
              end
            end
          end
        end
      end

      TRAIL: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_cs_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
`ifdef SPI_MASTER_MISO_EN
          w_rx_data_nxt = r_rx_shift;
`endif
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs   = r_cs;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_spi_master_tx.sv
// Two masters (CLK_DIV 2 and 1) on one clock. A reference model queues the
// expected frame (data, done time) for each accepted start; a bus monitor
// decodes each frame as a slave would and pops/compares at frame end.
module tb_spi_master_tx;

  localparam int unsigned DIV0 = 2;
  localparam int unsigned DIV1 = 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned when;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_w [2];
  logic [7:0] din_w   [2];
  logic       sclk_w  [2];
  logic       mosi_w  [2];
  logic       cs_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];
`ifdef SPI_MASTER_MISO_EN
  logic [7:0] rx_w    [2];
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned cyc    = 0;

  exp_t q0[$];
  exp_t q1[$];
  int unsigned next_free [2] = '{0, 0};

  // monitor state
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        prev_mosi [2] = '{1'b0, 1'b0};
  logic        prev_cs   [2] = '{1'b1, 1'b1};
  int unsigned low_cnt   [2] = '{0, 0};
  int unsigned hi_cnt    [2] = '{0, 0};
  int unsigned high_cnt  [2] = '{0, 0};
  int unsigned last_gap  [2] = '{0, 0};
  int unsigned npulse    [2] = '{0, 0};
  int unsigned nfall     [2] = '{0, 0};
  int unsigned viol      [2] = '{0, 0};
  int unsigned idle_viol [2] = '{0, 0};
  logic [9:0]  pat       [2];

  always #5 clk = ~clk;

  spi_master_tx #(.CLK_DIV(DIV0), .DATA_W(8)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_w[0]),
    .din   (din_w[0]),
    .sclk  (sclk_w[0]),
    .mosi  (mosi_w[0]),
    .cs    (cs_w[0]),
    .busy  (busy_w[0]),
    .done  (done_w[0])
`ifdef SPI_MASTER_MISO_EN
    ,
    .miso    (mosi_w[0]),
    .rx_data (rx_w[0])
`endif
  );

  spi_master_tx #(.CLK_DIV(DIV1), .DATA_W(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_w[1]),
    .din   (din_w[1]),
    .sclk  (sclk_w[1]),
    .mosi  (mosi_w[1]),
    .cs    (cs_w[1]),
    .busy  (busy_w[1]),
    .done  (done_w[1])
`ifdef SPI_MASTER_MISO_EN
    ,
    .miso    (mosi_w[1]),
    .rx_data (rx_w[1])
`endif
  );

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: a start seen while the master is free begins a frame
  // whose done appears 22*CLK_DIV+1 cycles later; the done cycle itself is free.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      next_free[0] = 0;
      next_free[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (start_w[k] && (cyc >= next_free[k])) begin
          e.data = din_w[k];
          e.when = cyc + 22 * div_of(k) + 1;
          next_free[k] = e.when;
          if (k == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic frame_end(input int k);
    exp_t e;
    bit   have;
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("dut%0d_end_done_busy_sclk", k),
        {29'd0, done_w[k], busy_w[k], sclk_w[k]}, 32'd4);
    chk($sformatf("dut%0d_frame_expected", k), {31'd0, have}, 32'd1);
    if (have) begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("dut%0d_mosi_pattern", k), {22'd0, pat[k]}, {22'd0, 1'b0, e.data, 1'b0});
      chk($sformatf("dut%0d_pulses_falls", k), npulse[k] * 256 + nfall[k], 32'd10 * 256 + 32'd10);
      chk($sformatf("dut%0d_cs_low_cycles", k), low_cnt[k], 22 * div_of(k));
      chk($sformatf("dut%0d_sclk_high_cycles", k), hi_cnt[k], 10 * div_of(k));
      chk($sformatf("dut%0d_done_time", k), cyc, e.when);
      chk($sformatf("dut%0d_frame_rule_violations", k), viol[k], 0);
`ifdef SPI_MASTER_MISO_EN
      chk($sformatf("dut%0d_rx_data", k), {24'd0, rx_w[k]}, {24'd0, e.data});
`endif
    end
  endtask

  // Bus monitor acting as the downstream slave: samples mosi on falling sclk.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_sclk[k] = 1'b0;
        prev_mosi[k] = 1'b0;
        prev_cs[k]   = 1'b1;
        low_cnt[k]   = 0;
        hi_cnt[k]    = 0;
        high_cnt[k]  = 0;
        npulse[k]    = 0;
        nfall[k]     = 0;
        viol[k]      = 0;
        pat[k]       = '0;
      end else begin
        logic rise, fall, csfall;
        rise   = !prev_sclk[k] && sclk_w[k];
        fall   = prev_sclk[k] && !sclk_w[k];
        csfall = prev_cs[k] && !cs_w[k];
        if (csfall) begin
          last_gap[k] = high_cnt[k];
          low_cnt[k]  = 0;
          hi_cnt[k]   = 0;
          npulse[k]   = 0;
          nfall[k]    = 0;
          viol[k]     = 0;
          pat[k]      = '0;
        end
        if (!cs_w[k]) begin
          high_cnt[k] = 0;
          low_cnt[k]++;
          if (sclk_w[k]) hi_cnt[k]++;
          if (rise) npulse[k]++;
          if (fall) begin
            pat[k] = {pat[k][8:0], mosi_w[k]};
            nfall[k]++;
          end
          if ((mosi_w[k] != prev_mosi[k]) && !rise && !csfall) viol[k]++;
          if (!busy_w[k] || done_w[k]) viol[k]++;
        end else begin
          high_cnt[k]++;
          if (!prev_cs[k]) frame_end(k);
          else if (done_w[k] || sclk_w[k] || mosi_w[k]) idle_viol[k]++;
        end
        prev_sclk[k] = sclk_w[k];
        prev_mosi[k] = mosi_w[k];
        prev_cs[k]   = cs_w[k];
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (!((q0.size() == 0) && (q1.size() == 0) && cs_w[0] && cs_w[1] &&
             !busy_w[0] && !busy_w[1]) && (n < 3000)) begin
      step();
      n++;
    end
    chk("wait_idle_in_time", {31'd0, (n < 3000)}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_dut%0d_cs_sclk_mosi_busy_done", nm, k),
          {27'd0, cs_w[k], sclk_w[k], mosi_w[k], busy_w[k], done_w[k]}, 32'h10);
`ifdef SPI_MASTER_MISO_EN
      chk($sformatf("%s_dut%0d_rx_data", nm, k), {24'd0, rx_w[k]}, 32'd0);
`endif
    end
  endtask

  task automatic send(input int k, input logic [7:0] d);
    din_w[k]   = d;
    start_w[k] = 1'b1;
    step();
    start_w[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    start_w = '{1'b0, 1'b0};
    din_w   = '{8'h00, 8'h00};
    rst_n   = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // nominal byte, CLK_DIV=2
    send(0, 8'hA5);
    wait_idle();

    // start while busy is ignored
    send(0, 8'h3C);
    repeat (8) step();
    send(0, 8'hFF);
    wait_idle();

    // loopback byte (rx path when enabled)
    send(0, 8'hC3);
    wait_idle();
    repeat (4) step();
`ifdef SPI_MASTER_MISO_EN
    chk("rx_hold_after_done", {24'd0, rx_w[0]}, 32'hC3);
`endif

    // back-to-back with start held, CLK_DIV=1
    din_w[1]   = 8'h01;
    start_w[1] = 1'b1;
    repeat (5) step();
    din_w[1] = 8'h80;
    repeat (25) step();
    start_w[1] = 1'b0;
    wait_idle();
    chk("back_to_back_gap", last_gap[1], 32'd1);

    // minimum divider, all-zero and all-one data
    send(1, 8'h00);
    wait_idle();
    send(1, 8'hFF);
    wait_idle();

    // randomized traffic, including starts issued while busy
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 12; i++) begin
        din_w[k]   = 8'($urandom);
        start_w[k] = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        start_w[k] = 1'b0;
        repeat ($urandom_range(0, 30)) begin
          din_w[k] = 8'($urandom);
          step();
        end
      end
      wait_idle();
    end

    // reset in the middle of pulse p=4
    send(0, 8'($urandom));
    n = 0;
    while ((npulse[0] < 5) && (n < 200)) begin
      step();
      n++;
    end
    chk("reached_pulse4", {31'd0, (npulse[0] == 5)}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midframe_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    send(0, 8'h5A);
    wait_idle();

    chk("idle_violations_dut0", idle_viol[0], 32'd0);
    chk("idle_violations_dut1", idle_viol[1], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
